pci_conf_cycle_ctrl: RTL and testbench

Wishbone slave that answers host accesses to the bridge's CNF_ADDR (12'h1E0), CNF_DATA (12'h1E4) and INT_ACK (12'h1E8) registers. It is the responder to the register-programming initiator. A CNF_DATA or INT_ACK access becomes a single PCI configuration or interrupt-acknowledge request to the PCI master over a req/done handshake. The Wishbone ack is held off until that PCI cycle completes or aborts.

---
 rtl/pci_conf_cycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pci_conf_cycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_conf_cycle_ctrl.sv
// pci_conf_cycle_ctrl: Wishbone slave for the bridge's CNF_ADDR, CNF_DATA and
// INT_ACK registers. CNF_DATA and INT_ACK accesses become one PCI configuration
// or interrupt-acknowledge request to the PCI master. The Wishbone ack is held
// until that request completes or aborts.
// Optional build macro: PCI_CONF_TIMEOUT_EN. When defined, a PCI request that
// waits TIMEOUT_CYCLES cycles without cyc_done_i is forced to an abort.
module pci_conf_cycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_IDSEL_DEV  = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [11:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        cyc_req_o,
    output logic [1:0]  cyc_type_o,
    output logic [31:0] cyc_addr_o,
    output logic [3:0]  cyc_be_o,
    output logic [31:0] cyc_wdata_o,
    input  logic        cyc_done_i,
    input  logic [31:0] cyc_rdata_i,
    input  logic        cyc_abort_i,
    output logic        conf_busy_o
);

    localparam logic [11:0] CNF_ADDR_OFS = 12'h1E0;
    localparam logic [11:0] CNF_DATA_OFS = 12'h1E4;
    localparam logic [11:0] INT_ACK_OFS  = 12'h1E8;
    localparam logic [1:0]  CYC_IACK     = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t      state;
    logic        cnf_abort;
    logic [23:0] cnf_addr;
    logic        wb_dropped;

    logic        take;
    logic        hit_addr;
    logic        hit_data;
    logic        hit_iack;
    logic [4:0]  cnf_dev;
    logic        cnf_type0;
    logic        idsel_ok;
    logic [31:0] cfg_addr;
    logic        timed_out;
    logic        finish_now;
    logic        abort_now;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    // Access decode and PCI configuration address generation
    always_comb begin
        // While ack/err is showing, the master's strobe belongs to the finished access
        take      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
        hit_addr  = (wb_adr_i == CNF_ADDR_OFS);
        hit_data  = (wb_adr_i == CNF_DATA_OFS);
        hit_iack  = (wb_adr_i == INT_ACK_OFS);
        cnf_dev   = cnf_addr[15:11];
        cnf_type0 = (cnf_addr[1:0] == 2'b00);
        idsel_ok  = (32'(cnf_dev) <= MAX_IDSEL_DEV);
        if (cnf_type0) begin
            cfg_addr = (32'h0000_0800 << cnf_dev) | {21'b0, cnf_addr[10:2], 2'b00};
        end else begin
            cfg_addr = {8'h00, cnf_addr[23:2], 2'b01};
        end
        finish_now = cyc_done_i | timed_out;
        abort_now  = cyc_done_i ? cyc_abort_i : timed_out;
    end

`ifdef PCI_CONF_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Count cycles spent waiting on the PCI master; cleared outside ISSUE
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE && !cyc_done_i) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign timed_out = (state == ISSUE) && (tmo_cnt == TMO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    // Control FSM, CNF_ADDR register and all registered outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnf_abort   <= 1'b0;
            cnf_addr    <= '0;
            wb_dropped  <= 1'b0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            cyc_req_o   <= 1'b0;
            cyc_type_o  <= '0;
            cyc_addr_o  <= '0;
            cyc_be_o    <= '0;
            cyc_wdata_o <= '0;
            conf_busy_o <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            case (state)
                IDLE: begin
                    if (take) begin
                        if (hit_addr) begin
                            wb_ack_o <= 1'b1;
                            if (wb_we_i) begin
                                if (wb_sel_i[0]) cnf_addr[7:0]   <= wb_dat_i[7:0];
                                if (wb_sel_i[1]) cnf_addr[15:8]  <= wb_dat_i[15:8];
                                if (wb_sel_i[2]) cnf_addr[23:16] <= wb_dat_i[23:16];
                                if (wb_sel_i[3] && wb_dat_i[31]) cnf_abort <= 1'b0;
                            end else begin
                                wb_dat_o <= {cnf_abort, 7'b0, cnf_addr};
                            end
                        end else if (hit_iack && !wb_we_i) begin
                            cyc_req_o   <= 1'b1;
                            conf_busy_o <= 1'b1;
                            cyc_type_o  <= CYC_IACK;
                            cyc_addr_o  <= '0;
                            cyc_be_o    <= '1;
                            cyc_wdata_o <= wb_dat_i;
                            wb_dropped  <= 1'b0;
                            state       <= ISSUE;
                        end else if (hit_data) begin
                            if (cnf_type0 && !idsel_ok) begin
                                // No IDSEL line exists for this device: fail locally
                                wb_ack_o  <= 1'b1;
                                cnf_abort <= 1'b1;
                                if (!wb_we_i) wb_dat_o <= '1;
                            end else begin
                                cyc_req_o   <= 1'b1;
                                conf_busy_o <= 1'b1;
                                cyc_type_o  <= {1'b0, wb_we_i};
                                cyc_addr_o  <= cfg_addr;
                                cyc_be_o    <= wb_sel_i;
                                cyc_wdata_o <= wb_dat_i;
                                wb_dropped  <= 1'b0;
                                state       <= ISSUE;
                            end
                        end else begin
                            wb_err_o <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!wb_cyc_i) wb_dropped <= 1'b1;
                    if (finish_now) begin
                        cyc_req_o   <= 1'b0;
                        conf_busy_o <= 1'b0;
                        state       <= ACK;
                        if (abort_now) cnf_abort <= 1'b1;
                        // An abandoned Wishbone cycle still lets the PCI cycle finish
                        if (!wb_dropped && wb_cyc_i) begin
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= abort_now ? '1 : cyc_rdata_i;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_conf_cycle_ctrl.sv
// Testbench for pci_conf_cycle_ctrl: Wishbone host accesses with a PCI master
// responder, expected responses held in scoreboard queues.
module tb_pci_conf_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [11:0] adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        cyc_req_o;
    logic [1:0]  cyc_type_o;
    logic [31:0] cyc_addr_o;
    logic [3:0]  cyc_be_o;
    logic [31:0] cyc_wdata_o;
    logic        done = 1'b0;
    logic [31:0] rdata = '0;
    logic        abort = 1'b0;
    logic        conf_busy_o;

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [31:0] lat;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [3:0]  be;
        logic [31:0] wdata;
    } pci_exp_t;

    wb_exp_t  wb_q[$];
    pci_exp_t pci_q[$];

    pci_conf_cycle_ctrl #(
        .TIMEOUT_CYCLES(8),
        .MAX_IDSEL_DEV (20)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_dat_i   (wdat),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .cyc_req_o  (cyc_req_o),
        .cyc_type_o (cyc_type_o),
        .cyc_addr_o (cyc_addr_o),
        .cyc_be_o   (cyc_be_o),
        .cyc_wdata_o(cyc_wdata_o),
        .cyc_done_i (done),
        .cyc_rdata_i(rdata),
        .cyc_abort_i(abort),
        .conf_busy_o(conf_busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_ack_o) ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_wb(input logic err, input logic [31:0] data, input int lat);
        wb_exp_t e;
        e.err  = err;
        e.data = data;
        e.lat  = 32'(lat);
        wb_q.push_back(e);
    endtask

    task automatic exp_pci(input logic [31:0] a, input logic [1:0] t, input logic [3:0] b,
                           input logic [31:0] w);
        pci_exp_t p;
        p.addr  = a;
        p.typ   = t;
        p.be    = b;
        p.wdata = w;
        pci_q.push_back(p);
    endtask

    // One Wishbone access; response compared against the head of wb_q
    task automatic wb_access(input string tag, input logic w, input logic [11:0] a,
                             input logic [3:0] s, input logic [31:0] d);
        wb_exp_t e;
        int cnt;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        cnt = 0;
        while (!(wb_ack_o || wb_err_o) && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (wb_q.size() == 0) begin
            check({tag, "_sb"}, 32'd0, 32'd1);
        end else begin
            e = wb_q.pop_front();
            check({tag, "_resp"}, {31'b0, wb_ack_o | wb_err_o}, 32'd1);
            check({tag, "_err"}, {31'b0, wb_err_o}, {31'b0, e.err});
            check({tag, "_dat"}, wb_dat_o, e.data);
            check({tag, "_lat"}, 32'(cnt), e.lat);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
    endtask

    // PCI master model: waits for a request, checks it, then completes it
    task automatic pci_respond(input string tag, input logic [31:0] rd, input logic ab,
                               input int delay);
        pci_exp_t p;
        int cnt;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!cyc_req_o && cnt < 20);
        if (!cyc_req_o || pci_q.size() == 0) begin
            check({tag, "_req"}, {31'b0, cyc_req_o}, 32'd1);
        end else begin
            p = pci_q.pop_front();
            check({tag, "_addr"}, cyc_addr_o, p.addr);
            check({tag, "_type"}, {30'b0, cyc_type_o}, {30'b0, p.typ});
            check({tag, "_be"}, {28'b0, cyc_be_o}, {28'b0, p.be});
            check({tag, "_wdata"}, cyc_wdata_o, p.wdata);
            check({tag, "_busy"}, {31'b0, conf_busy_o}, 32'd1);
            repeat (delay) @(posedge clk);
            #1;
            done = 1'b1; rdata = rd; abort = ab;
            @(posedge clk); #1;
            done = 1'b0; rdata = '0; abort = 1'b0;
            check({tag, "_reqdrop"}, {31'b0, cyc_req_o}, 32'd0);
        end
    endtask

    task automatic pci_xfer(input string tag, input logic w, input logic [11:0] a,
                            input logic [3:0] s, input logic [31:0] d,
                            input logic [31:0] rd, input logic ab, input int delay);
        fork
            wb_access(tag, w, a, s, d);
            pci_respond(tag, rd, ab, delay);
        join
    endtask

    initial begin
        int a0;
        int cnt;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_err", {31'b0, wb_err_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_req", {31'b0, cyc_req_o}, 32'd0);
        check("rst_busy", {31'b0, conf_busy_o}, 32'd0);
        check("rst_addr", cyc_addr_o, 32'd0);
        rst = 1'b0;

        exp_wb(1'b0, 32'h0, 1);
        wb_access("rst_cnf", 1'b0, 12'h1E0, 4'hF, 32'h0);

        // Type 0 configuration read
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_addr0", 1'b1, 12'h1E0, 4'hF, 32'h0000_1804);
        exp_wb(1'b0, 32'h0000_1804, 1);
        wb_access("rd_addr0", 1'b0, 12'h1E0, 4'hF, 32'h0);
        exp_pci(32'h0000_4004, 2'b00, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h1234_5678, 4);
        pci_xfer("cfg_rd0", 1'b0, 12'h1E4, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 2);

        // Type 1 configuration write with partial byte enables
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_addr1", 1'b1, 12'h1E0, 4'hF, 32'h0005_2A09);
        exp_pci(32'h0005_2A09, 2'b01, 4'b0011, 32'hCAFE_F00D);
        exp_wb(1'b0, 32'h0, 3);
        pci_xfer("cfg_wr1", 1'b1, 12'h1E4, 4'b0011, 32'hCAFE_F00D, 32'h0, 1'b0, 1);

        // Master abort sets sticky ABORT, cleared by writing bit31
        exp_pci(32'h0005_2A09, 2'b00, 4'hF, 32'h0);
        exp_wb(1'b0, 32'hFFFF_FFFF, 2);
        pci_xfer("cfg_abort", 1'b0, 12'h1E4, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1, 0);
        exp_wb(1'b0, 32'h8005_2A09, 1);
        wb_access("rd_abort", 1'b0, 12'h1E0, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h0, 1);
        wb_access("clr_abort", 1'b1, 12'h1E0, 4'hF, 32'h8005_2A09);
        exp_wb(1'b0, 32'h0005_2A09, 1);
        wb_access("rd_clr", 1'b0, 12'h1E0, 4'hF, 32'h0);

        // Single-byte write honours wb_sel_i
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_byte2", 1'b1, 12'h1E0, 4'b0100, 32'hFFAA_FFFF);
        exp_wb(1'b0, 32'h00AA_2A09, 1);
        wb_access("rd_byte2", 1'b0, 12'h1E0, 4'hF, 32'h0);

        // Type value 2 is kept but addresses as type 1
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_type2", 1'b1, 12'h1E0, 4'hF, 32'h0001_0802);
        exp_wb(1'b0, 32'h0001_0802, 1);
        wb_access("rd_type2", 1'b0, 12'h1E0, 4'hF, 32'h0);
        exp_pci(32'h0001_0801, 2'b00, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h0BAD_F00D, 3);
        pci_xfer("cfg_type2", 1'b0, 12'h1E4, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 1);

        // Highest mappable device uses AD[31]
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_dev20", 1'b1, 12'h1E0, 4'hF, 32'h0000_A000);
        exp_pci(32'h8000_0000, 2'b00, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h0000_55AA, 2);
        pci_xfer("cfg_dev20", 1'b0, 12'h1E4, 4'hF, 32'h0, 32'h0000_55AA, 1'b0, 0);

        // Device 21 has no IDSEL: local failure, no PCI request
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_dev21", 1'b1, 12'h1E0, 4'hF, 32'h0000_A800);
        exp_wb(1'b0, 32'hFFFF_FFFF, 1);
        wb_access("cfg_dev21", 1'b0, 12'h1E4, 4'hF, 32'h0);
        check("dev21_noreq", {31'b0, cyc_req_o}, 32'd0);
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wrd_dev21", 1'b1, 12'h1E4, 4'hF, 32'h1111_2222);
        check("dev21w_noreq", {31'b0, cyc_req_o}, 32'd0);
        exp_wb(1'b0, 32'h8000_A800, 1);
        wb_access("rd_dev21", 1'b0, 12'h1E0, 4'hF, 32'h0);

        // Interrupt acknowledge forces address 0 and all byte enables
        exp_pci(32'h0, 2'b10, 4'hF, 32'h0);
        exp_wb(1'b0, 32'h0000_0042, 5);
        pci_xfer("iack", 1'b0, 12'h1E8, 4'b0001, 32'h0, 32'h0000_0042, 1'b0, 3);

        // Error responses
        exp_wb(1'b1, 32'h0, 1);
        wb_access("iack_wr", 1'b1, 12'h1E8, 4'hF, 32'h5);
        exp_wb(1'b1, 32'h0, 1);
        wb_access("bad_ofs", 1'b0, 12'h1F0, 4'hF, 32'h0);

        // Wishbone master gives up during ISSUE: PCI completes, no ack
        a0 = ack_cnt;
        exp_pci(32'h0, 2'b10, 4'hF, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h1E8; sel = 4'hF;
        fork
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                cyc = 1'b0; stb = 1'b0;
            end
            pci_respond("drop", 32'h77, 1'b0, 3);
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drop_noack", 32'(ack_cnt - a0), 32'd0);
        exp_wb(1'b0, 32'h8000_A800, 1);
        wb_access("rd_after_drop", 1'b0, 12'h1E0, 4'hF, 32'h0);

        // Reset while a PCI cycle is outstanding
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_addr_rst", 1'b1, 12'h1E0, 4'hF, 32'h8000_1804);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h1E4; sel = 4'hF;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!cyc_req_o && cnt < 20);
        check("rst_issue_req", {31'b0, cyc_req_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_req", {31'b0, cyc_req_o}, 32'd0);
        check("rst_async_busy", {31'b0, conf_busy_o}, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_wb(1'b0, 32'h0, 1);
        wb_access("rd_after_rst", 1'b0, 12'h1E0, 4'hF, 32'h0);

`ifdef PCI_CONF_TIMEOUT_EN
        // No completion from the PCI master: forced abort after 8 cycles
        exp_wb(1'b0, 32'h0, 1);
        wb_access("wr_addr_tmo", 1'b1, 12'h1E0, 4'hF, 32'h0000_1804);
        exp_wb(1'b0, 32'hFFFF_FFFF, 9);
        wb_access("tmo", 1'b0, 12'h1E4, 4'hF, 32'h0);
        check("tmo_reqdrop", {31'b0, cyc_req_o}, 32'd0);
        exp_wb(1'b0, 32'h8000_1804, 1);
        wb_access("rd_tmo", 1'b0, 12'h1E0, 4'hF, 32'h0);
`endif

        check("sb_wb_empty", 32'(wb_q.size()), 32'd0);
        check("sb_pci_empty", 32'(pci_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
